axi_sdcard_lite_arbiter: RTL and testbench

// Shares the single AXI4-Lite register slave of the SD-card block (NUM_REGS 32-bit registers) between two

---
 rtl/axi_sdcard_lite_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_axi_sdcard_lite_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sdcard_lite_arbiter.sv
// axi_sdcard_lite_arbiter: round-robin sharing of one AXI4-Lite register slave between two requesters
module axi_sdcard_lite_arbiter #(
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 4
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_wr,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [63:0]         req_wdata,
   output logic [1:0]          req_ready,
   output logic [1:0]          cpl_valid,
   output logic [31:0]         cpl_rdata,
   output logic [1:0]          cpl_resp,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [31:0]         m_axi_wdata,
   output logic [3:0]          m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [2:0]          m_axi_arprot,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [31:0]         m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready
);
   typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, ERR, DONE} state_t;
   state_t state_q, state_d;
   logic g_q, g_d, rr_q, rr_d, sel, bad;
   logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
   logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, crd_q, crd_d;
   logic [1:0] resp_q, resp_d, crs_q, crs_d, rdy_q, rdy_d, cv_q, cv_d;
   logic [3:0] wstrb_q, wstrb_d;
   logic awv_q, awv_d, wv_q, wv_d, bry_q, bry_d, arv_q, arv_d, rry_q, rry_d;

   // grant selection, command latch and AXI channel sequencing; every output is a flop
   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      rr_d     = rr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      resp_d   = resp_q;
      wstrb_d  = wstrb_q;
      awv_d    = awv_q;
      wv_d     = wv_q;
      bry_d    = bry_q;
      arv_d    = arv_q;
      rry_d    = rry_q;
      rdy_d    = 2'b00;
      cv_d     = 2'b00;
      crd_d    = '0;
      crs_d    = '0;
      sel      = req_valid[rr_q] ? rr_q : ~rr_q;
      sel_addr = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      bad      = (sel_addr[1:0] != 2'b00) || (32'(sel_addr) >= 32'(4*NUM_REGS));
      case (state_q)
         IDLE: if (|req_valid) begin
            g_d     = sel;
            rdy_d   = sel ? 2'b10 : 2'b01;
            addr_d  = sel_addr;
            wdata_d = sel ? req_wdata[63:32] : req_wdata[31:0];
            wstrb_d = req_wr[sel] ? 4'hF : 4'h0;
            if (bad) state_d = ERR;
            else if (req_wr[sel]) begin
               state_d = WR;
               awv_d   = 1'b1;
               wv_d    = 1'b1;
            end else begin
               state_d = RA;
               arv_d   = 1'b1;
            end
         end
         WR: begin
            awv_d = awv_q & ~m_axi_awready;
            wv_d  = wv_q & ~m_axi_wready;
            if (!awv_d && !wv_d) begin
               state_d = WB;
               bry_d   = 1'b1;
            end
         end
         WB: if (m_axi_bvalid) begin
            bry_d   = 1'b0;
            resp_d  = m_axi_bresp;
            rdata_d = '0;
            state_d = DONE;
         end
         RA: if (m_axi_arready) begin
            arv_d   = 1'b0;
            rry_d   = 1'b1;
            state_d = RD;
         end
         RD: if (m_axi_rvalid) begin
            rry_d   = 1'b0;
            rdata_d = m_axi_rdata;
            resp_d  = m_axi_rresp;
            state_d = DONE;
         end
         ERR: begin
            resp_d  = 2'b10;
            rdata_d = '0;
            state_d = DONE;
         end
         DONE: begin
            cv_d    = g_q ? 2'b10 : 2'b01;
            crd_d   = rdata_q;
            crs_d   = resp_q;
            rr_d    = ~g_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register; reset abandons any transaction in flight
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         g_q     <= 1'b0;
         rr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= '0;
         wstrb_q <= '0;
         awv_q   <= 1'b0;
         wv_q    <= 1'b0;
         bry_q   <= 1'b0;
         arv_q   <= 1'b0;
         rry_q   <= 1'b0;
         rdy_q   <= '0;
         cv_q    <= '0;
         crd_q   <= '0;
         crs_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
         wstrb_q <= wstrb_d;
         awv_q   <= awv_d;
         wv_q    <= wv_d;
         bry_q   <= bry_d;
         arv_q   <= arv_d;
         rry_q   <= rry_d;
         rdy_q   <= rdy_d;
         cv_q    <= cv_d;
         crd_q   <= crd_d;
         crs_q   <= crs_d;
      end
   end

   assign req_ready     = rdy_q;
   assign cpl_valid     = cv_q;
   assign cpl_rdata     = crd_q;
   assign cpl_resp      = crs_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awv_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wv_q;
   assign m_axi_bready  = bry_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arv_q;
   assign m_axi_rready  = rry_q;
endmodule

// File: tb/tb_axi_sdcard_lite_arbiter.sv
// tb_axi_sdcard_lite_arbiter: randomized bench with AXI4-Lite slave model and transaction-level reference
module tb_axi_sdcard_lite_arbiter;
   localparam int AW = 5;
   localparam int NREGS = 4;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] req_valid, req_wr, req_ready, cpl_valid, cpl_resp;
   logic [2*AW-1:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] cpl_rdata, wdata, rdata;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;

   logic auto_rdy, fast, man_aw, man_w, hold_r;
   logic rnd_aw, rnd_w, rnd_ar, rnd_go, s_go;
   logic [1:0] slv_resp;
   logic got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
   logic [AW-1:0] s_awa, s_ara;
   logic [31:0] s_wd;
   logic [3:0] s_ws;
   logic [31:0] smem [8];
   logic [31:0] mmem [4];
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, aw_hi = 0, w_hi = 0, any_v = 0;
   int checks, errors, pref;
   logic [94:0] all_out;

   assign all_out = {req_ready, cpl_valid, cpl_rdata, cpl_resp, awaddr, awprot, awvalid, wdata, wstrb,
                     wvalid, bready, araddr, arprot, arvalid, rready};

   axi_sdcard_lite_arbiter #(.ADDR_W(AW), .NUM_REGS(NREGS)) dut (
      .ACLK(clk), .ARESET(rst),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .cpl_valid(cpl_valid), .cpl_rdata(cpl_rdata), .cpl_resp(cpl_resp),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   assign awready = auto_rdy ? rnd_aw : man_aw;
   assign wready  = auto_rdy ? rnd_w : man_w;
   assign arready = rnd_ar;
   assign s_go    = rnd_go & ~hold_r;

   // slave readiness, randomised per cycle unless fast
   always @(negedge clk) begin
      rnd_aw = fast | ($urandom % 2 == 0);
      rnd_w  = fast | ($urandom % 2 == 0);
      rnd_ar = fast | ($urandom % 2 == 0);
      rnd_go = fast | ($urandom % 2 == 0);
   end

   // AXI4-Lite slave model with handshake monitors
   always @(posedge clk) begin
      if (rst) begin
         got_aw <= 1'b0;
         got_w  <= 1'b0;
         got_ar <= 1'b0;
         bvalid <= 1'b0;
         rvalid <= 1'b0;
      end else begin
         if (awvalid && awready) begin
            got_aw <= 1'b1;
            s_awa  <= awaddr;
            aw_hs  <= aw_hs + 1;
         end
         if (wvalid && wready) begin
            got_w <= 1'b1;
            s_wd  <= wdata;
            s_ws  <= wstrb;
            w_hs  <= w_hs + 1;
         end
         if (got_aw && got_w && !bvalid && s_go) begin
            smem[s_awa[4:2]] <= s_wd;
            bvalid <= 1'b1;
            bresp  <= slv_resp;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            b_hs   <= b_hs + 1;
         end
         if (arvalid && arready) begin
            got_ar <= 1'b1;
            s_ara  <= araddr;
            ar_hs  <= ar_hs + 1;
         end
         if (got_ar && !rvalid && s_go) begin
            rvalid <= 1'b1;
            rdata  <= smem[s_ara[4:2]];
            rresp  <= slv_resp;
            got_ar <= 1'b0;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if (awvalid || wvalid || arvalid) any_v <= any_v + 1;
   end

   task automatic model_txn(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                            output logic [31:0] erd, output logic [1:0] ers);
      int idx;
      idx = int'(a) / 4;
      erd = '0;
      ers = 2'b10;
      if (a[1:0] == 2'b00 && int'(a) < 4 * NREGS) begin
         ers = slv_resp;
         if (wr) mmem[idx] = d;
         else erd = mmem[idx];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      pref = 0;
   endtask

   task automatic do_txn(input int n, input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         output logic [1:0] rdy, output logic [1:0] cv, output logic [31:0] rd,
                         output logic [1:0] rs, output int lat);
      int t;
      @(negedge clk);
      req_valid[n] = 1'b1;
      req_wr[n] = wr;
      req_addr[n*AW +: AW] = a;
      req_wdata[n*32 +: 32] = d;
      t = 0;
      while (req_ready == 2'b00 && t < 50) begin
         @(negedge clk);
         t++;
      end
      rdy = req_ready;
      req_valid[n] = 1'b0;
      lat = 0;
      while (cpl_valid == 2'b00 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      cv = cpl_valid;
      rd = cpl_rdata;
      rs = cpl_resp;
      pref = 1 - n;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", all_out);
      end
   endtask

   task automatic test_write_basic();
      logic [1:0] rdy, cv, rs, ers;
      logic [31:0] rd, erd;
      int lat, aw0, w0;
      fast = 1'b1;
      slv_resp = 2'b00;
      aw0 = aw_hs;
      w0 = w_hs;
      model_txn(1'b1, 5'h00, 32'h1, erd, ers);
      do_txn(0, 1'b1, 5'h00, 32'h1, rdy, cv, rd, rs, lat);
      checks++;
      if (rdy !== 2'b01) begin errors++; $display("FAIL wr1_ready got %b want 01", rdy); end
      checks++;
      if (cv !== 2'b01) begin errors++; $display("FAIL wr1_cpl got %b want 01", cv); end
      checks++;
      if ({rd, rs} !== {erd, ers}) begin errors++; $display("FAIL wr1_data got %h/%b want %h/%b", rd, rs, erd, ers); end
      checks++;
      if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
         errors++;
         $display("FAIL wr1_beats got aw %0d w %0d want 1 1", aw_hs - aw0, w_hs - w0);
      end
      checks++;
      if (s_ws !== 4'hF) begin errors++; $display("FAIL wr1_wstrb got %h want f", s_ws); end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL wr1_latency got %0d want 4", lat); end
      model_txn(1'b0, 5'h00, 32'h0, erd, ers);
      do_txn(0, 1'b0, 5'h00, 32'h0, rdy, cv, rd, rs, lat);
      checks++;
      if (lat != 4 || rd !== erd) begin errors++; $display("FAIL rd1 got lat %0d data %h want 4 %h", lat, rd, erd); end
   endtask

   task automatic test_fill_readback();
      logic [1:0] rdy, cv, rs, ers;
      logic [31:0] rd, erd;
      int lat;
      fast = 1'b0;
      slv_resp = 2'b00;
      for (int i = 0; i < 4; i++) begin
         model_txn(1'b1, AW'(4 * i), 32'(i + 1), erd, ers);
         do_txn(1, 1'b1, AW'(4 * i), 32'(i + 1), rdy, cv, rd, rs, lat);
         checks++;
         if (cv !== 2'b10 || rs !== ers) begin errors++; $display("FAIL fill_wr%0d got %b/%b want 10/%b", i, cv, rs, ers); end
      end
      for (int i = 0; i < 4; i++) begin
         model_txn(1'b0, AW'(4 * i), 32'h0, erd, ers);
         do_txn(0, 1'b0, AW'(4 * i), 32'h0, rdy, cv, rd, rs, lat);
         checks++;
         if (cv !== 2'b01 || rd !== erd || rs !== ers) begin
            errors++;
            $display("FAIL fill_rd%0d got %b/%h/%b want 01/%h/%b", i, cv, rd, rs, erd, ers);
         end
      end
   endtask

   task automatic test_error();
      logic [1:0] rdy, cv, rs, ers;
      logic [31:0] rd, erd;
      int lat, v0;
      fast = 1'b1;
      slv_resp = 2'b00;
      v0 = any_v;
      model_txn(1'b0, 5'h06, 32'h0, erd, ers);
      do_txn(0, 1'b0, 5'h06, 32'h0, rdy, cv, rd, rs, lat);
      checks++;
      if (cv !== 2'b01 || rs !== ers || rd !== erd) begin
         errors++;
         $display("FAIL err_misaligned got %b/%b/%h want 01/%b/%h", cv, rs, rd, ers, erd);
      end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL err_latency got %0d want 2", lat); end
      model_txn(1'b1, 5'h10, 32'hDEAD_BEEF, erd, ers);
      do_txn(1, 1'b1, 5'h10, 32'hDEAD_BEEF, rdy, cv, rd, rs, lat);
      checks++;
      if (cv !== 2'b10 || rs !== ers || rd !== erd) begin
         errors++;
         $display("FAIL err_range got %b/%b/%h want 10/%b/%h", cv, rs, rd, ers, erd);
      end
      checks++;
      if (any_v != v0) begin errors++; $display("FAIL err_no_axi got %0d valid cycles want 0", any_v - v0); end
   endtask

   task automatic test_random();
      logic [1:0] rdy, cv, rs, ers, en;
      logic [31:0] rd, erd, d;
      logic [AW-1:0] a;
      int lat, n;
      bit wr;
      fast = 1'b0;
      for (int i = 0; i < 30; i++) begin
         n = int'($urandom % 2);
         wr = 1'($urandom % 2);
         a = AW'($urandom % 32);
         d = $urandom;
         slv_resp = 2'($urandom % 4);
         en = (n == 1) ? 2'b10 : 2'b01;
         model_txn(wr, a, d, erd, ers);
         do_txn(n, wr, a, d, rdy, cv, rd, rs, lat);
         checks++;
         if (rdy !== en || cv !== en || rd !== erd || rs !== ers) begin
            errors++;
            $display("FAIL random%0d got rdy %b cpl %b %h/%b want %b %b %h/%b", i, rdy, cv, rd, rs, en, en, erd, ers);
         end
      end
   endtask

   task automatic test_round_robin();
      bit c_wr [2];
      logic [AW-1:0] c_a [2];
      logic [31:0] c_d [2];
      logic [31:0] erd;
      logic [1:0] ers, eg;
      int t, gr;
      do_reset();
      fast = 1'b0;
      slv_resp = 2'b00;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         c_wr[n] = 1'($urandom % 2);
         c_a[n] = AW'(4 * ($urandom % 4));
         c_d[n] = $urandom;
         req_wr[n] = c_wr[n];
         req_addr[n*AW +: AW] = c_a[n];
         req_wdata[n*32 +: 32] = c_d[n];
      end
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (req_ready == 2'b00 && t < 50) begin
            @(negedge clk);
            t++;
         end
         gr = pref;
         eg = (gr == 1) ? 2'b10 : 2'b01;
         checks++;
         if (req_ready !== eg) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, eg); end
         model_txn(c_wr[gr], c_a[gr], c_d[gr], erd, ers);
         c_wr[gr] = 1'($urandom % 2);
         c_a[gr] = AW'(4 * ($urandom % 4));
         c_d[gr] = $urandom;
         req_wr[gr] = c_wr[gr];
         req_addr[gr*AW +: AW] = c_a[gr];
         req_wdata[gr*32 +: 32] = c_d[gr];
         t = 0;
         while (cpl_valid == 2'b00 && t < 200) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (cpl_valid !== eg || cpl_rdata !== erd || cpl_resp !== ers) begin
            errors++;
            $display("FAIL rr_cpl%0d got %b %h/%b want %b %h/%b", k, cpl_valid, cpl_rdata, cpl_resp, eg, erd, ers);
         end
         pref = 1 - gr;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_split_ready();
      logic [1:0] rdy, cv, rs, ers;
      logic [31:0] rd, erd;
      int lat, ah0, wh0, aw0, w0, b0;
      fast = 1'b1;
      slv_resp = 2'b00;
      auto_rdy = 1'b0;
      man_aw = 1'b0;
      man_w = 1'b1;
      ah0 = aw_hi; wh0 = w_hi; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      model_txn(1'b1, 5'h08, 32'hA5A5_0001, erd, ers);
      fork
         do_txn(0, 1'b1, 5'h08, 32'hA5A5_0001, rdy, cv, rd, rs, lat);
         begin
            int t2;
            t2 = 0;
            @(negedge clk);
            while (req_ready[0] !== 1'b1 && t2 < 50) begin
               @(negedge clk);
               t2++;
            end
            repeat (3) @(negedge clk);
            man_aw = 1'b1;
         end
      join
      checks++;
      if (aw_hi - ah0 != 4 || w_hi - wh0 != 1) begin
         errors++;
         $display("FAIL split_valid_cycles got aw %0d w %0d want 4 1", aw_hi - ah0, w_hi - wh0);
      end
      checks++;
      if (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
         errors++;
         $display("FAIL split_beats got %0d %0d %0d want 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
      end
      checks++;
      if (cv !== 2'b01 || rs !== ers) begin errors++; $display("FAIL split_cpl got %b/%b want 01/%b", cv, rs, ers); end
      auto_rdy = 1'b1;
      man_aw = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] rdy, cv, rs, ers, seen;
      logic [31:0] rd, erd;
      int lat, t;
      fast = 1'b1;
      slv_resp = 2'b00;
      hold_r = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_wr[0] = 1'b0;
      req_addr[AW-1:0] = 5'h04;
      t = 0;
      while (req_ready[0] !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      req_valid[0] = 1'b0;
      t = 0;
      while (rready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (rready !== 1'b1) begin errors++; $display("FAIL mid_reach_rd got %b want 1", rready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pref = 0;
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", all_out); end
      seen = 2'b00;
      repeat (5) begin
         @(negedge clk);
         seen |= cpl_valid;
      end
      checks++;
      if (seen !== 2'b00) begin errors++; $display("FAIL mid_no_cpl got %b want 00", seen); end
      hold_r = 1'b0;
      model_txn(1'b0, 5'h04, 32'h0, erd, ers);
      do_txn(0, 1'b0, 5'h04, 32'h0, rdy, cv, rd, rs, lat);
      checks++;
      if (cv !== 2'b01 || rd !== erd || rs !== ers) begin
         errors++;
         $display("FAIL mid_after got %b %h/%b want 01 %h/%b", cv, rd, rs, erd, ers);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_wr = '0;
      req_addr = '0;
      req_wdata = '0;
      auto_rdy = 1'b1;
      fast = 1'b1;
      man_aw = 1'b0;
      man_w = 1'b0;
      hold_r = 1'b0;
      slv_resp = 2'b00;
      checks = 0;
      errors = 0;
      pref = 0;
      for (int i = 0; i < 4; i++) mmem[i] = '0;
      test_reset();
      test_write_basic();
      test_fill_readback();
      test_error();
      test_random();
      test_round_robin();
      test_split_ready();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
